// File: rtl/dogx_output_decimator.sv
// dogx_output_decimator
//   Boxcar decimator for the merged 11-bit converter sample. Sums R = 2**LOG2_R consecutive
//   samples at the 3 MHz tick rate and queues each full-precision sum, tagged with its range
//   (alpha), in a small show-ahead FIFO drained over a valid/ready handshake. Any window that
//   spans an alpha change is discarded, and a few samples after the change are skipped so the
//   converter can settle.
// Ports
//   CLK_24M      system clock
//   reset        synchronous, active-low reset
//   sample_tick  one-cycle strobe per new sample
//   sample_in    signed sample, valid with sample_tick
//   alpha_in     range select accompanying sample_in (1 = HDR)
//   dec_enable   1 = decimate, 0 = idle (FIFO contents kept)
//   out_data     signed window sum at FIFO head (0 when empty)
//   out_alpha    alpha of the head window (0 when empty)
//   out_valid    FIFO not empty
//   out_ready    downstream accepts head when out_valid && out_ready
//   fifo_level   entries held
//   overflow     sticky: a completed window was dropped because the FIFO was full
module dogx_output_decimator #(
  parameter int unsigned DATA_W         = 11,
  parameter int unsigned LOG2_R         = 3,
  parameter int unsigned SETTLE_SAMPLES = 2,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                               CLK_24M,
  input  logic                               reset,
  input  logic                               sample_tick,
  input  logic [DATA_W-1:0]                  sample_in,
  input  logic                               alpha_in,
  input  logic                               dec_enable,
  output logic [DATA_W+LOG2_R-1:0]           out_data,
  output logic                               out_alpha,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow
);

  localparam int unsigned SUM_W = DATA_W + LOG2_R;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned SET_W = $clog2(SETTLE_SAMPLES + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StSettle} state_e;

  state_e             state_q;
  logic [SUM_W-1:0]   acc_q;
  logic [LOG2_R-1:0]  cnt_q;
  logic [SET_W-1:0]   settle_q;
  logic               alpha_q;

  logic [SUM_W-1:0]   sample_ext;
  logic [SUM_W-1:0]   sum_full;
  logic               win_last;
  logic               alpha_chg;
  logic               push;

  // Sum of R sign-extended samples always fits in SUM_W bits, so no saturation is needed.
  assign sample_ext = {{LOG2_R{sample_in[DATA_W-1]}}, sample_in};
  assign sum_full   = acc_q + sample_ext;
  assign win_last   = (cnt_q == {LOG2_R{1'b1}});
  assign alpha_chg  = (alpha_in != alpha_q);

  // Push is decoded combinationally so the word reaches the FIFO on the last tick's edge.
  always_comb begin
    push = 1'b0;
    if (dec_enable && (state_q == StAccum) && sample_tick && !alpha_chg && win_last) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (!reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      alpha_q  <= 1'b0;
    end else if (!dec_enable) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StAccum;
          acc_q   <= '0;
          cnt_q   <= '0;
          alpha_q <= alpha_in;
        end
        StAccum: begin
          if (sample_tick) begin
            if (alpha_chg) begin
              // Range changed: the partial window mixes scalings, so throw it away.
              acc_q    <= '0;
              cnt_q    <= '0;
              alpha_q  <= alpha_in;
              settle_q <= SET_W'(SETTLE_SAMPLES);
              state_q  <= StSettle;
            end else if (!win_last) begin
              acc_q <= sum_full;
              cnt_q <= cnt_q + LOG2_R'(1);
            end else begin
              acc_q <= '0;
              cnt_q <= '0;
            end
          end
        end
        StSettle: begin
          if (sample_tick) begin
            if (alpha_chg) begin
              alpha_q  <= alpha_in;
              settle_q <= SET_W'(SETTLE_SAMPLES);
            end else begin
              settle_q <= settle_q - SET_W'(1);
              if (settle_q == SET_W'(1)) begin
                state_q <= StAccum;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output FIFO: entry = {sum, alpha}
  logic [SUM_W:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic [SUM_W:0]     head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  // A simultaneous pop frees a slot, so a push into a full FIFO still succeeds.
  assign wr_en     = push && (!full || pop);

  always_ff @(posedge CLK_24M) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {sum_full, alpha_q};
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (wr_en && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (!wr_en && pop) begin
        level_q <= level_q - LVL_W'(1);
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Head is forced to zero when empty so stale storage never shows on the outputs.
  assign head       = mem_q[rd_ptr_q];
  assign out_data   = out_valid ? head[SUM_W:1] : '0;
  assign out_alpha  = out_valid ? head[0] : 1'b0;
  assign fifo_level = level_q;

endmodule
